// File: rtl/vmem_lane_responder_if.sv
// rtl/vmem_lane_responder_if.sv - request/response bundle between vector lanes and the data-memory responder
`ifndef PC_ADDR_BITS
`define PC_ADDR_BITS 32
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

interface vmem_lane_responder_if;
   logic                       req_valid;
   logic                       req_ready;
   logic                       req_is_store;
   logic [3:0]                 req_lane_en;
   logic [`PC_ADDR_BITS-1:0]   req_addr0;
   logic [`PC_ADDR_BITS-1:0]   req_addr1;
   logic [`PC_ADDR_BITS-1:0]   req_addr2;
   logic [`PC_ADDR_BITS-1:0]   req_addr3;
   logic [`DATAMEM_WIDTH-1:0]  req_wdata0;
   logic [`DATAMEM_WIDTH-1:0]  req_wdata1;
   logic [`DATAMEM_WIDTH-1:0]  req_wdata2;
   logic [`DATAMEM_WIDTH-1:0]  req_wdata3;
   logic                       rsp_valid;
   logic                       rsp_ready;
   logic                       rsp_is_store;
   logic [`DATAMEM_WIDTH-1:0]  rsp_rdata0;
   logic [`DATAMEM_WIDTH-1:0]  rsp_rdata1;
   logic [`DATAMEM_WIDTH-1:0]  rsp_rdata2;
   logic [`DATAMEM_WIDTH-1:0]  rsp_rdata3;
`ifdef VMEM_OOB_ERR_EN
   logic                       rsp_err;
`endif

   modport master (
`ifdef VMEM_OOB_ERR_EN
      input  rsp_err,
`endif
      output req_valid, req_is_store, req_lane_en,
      output req_addr0, req_addr1, req_addr2, req_addr3,
      output req_wdata0, req_wdata1, req_wdata2, req_wdata3,
      input  req_ready,
      input  rsp_valid, rsp_is_store,
      input  rsp_rdata0, rsp_rdata1, rsp_rdata2, rsp_rdata3,
      output rsp_ready
   );

   modport slave (
`ifdef VMEM_OOB_ERR_EN
      output rsp_err,
`endif
      input  req_valid, req_is_store, req_lane_en,
      input  req_addr0, req_addr1, req_addr2, req_addr3,
      input  req_wdata0, req_wdata1, req_wdata2, req_wdata3,
      output req_ready,
      output rsp_valid, rsp_is_store,
      output rsp_rdata0, rsp_rdata1, rsp_rdata2, rsp_rdata3,
      input  rsp_ready
   );
endinterface

// File: rtl/vmem_lane_responder.sv
// rtl/vmem_lane_responder.sv - 4-lane vector data-memory responder serializing lanes onto PORTS RAM ports
// Optional VMEM_OOB_ERR_EN: out-of-range lanes are suppressed and flagged on rsp_err.
`ifndef PC_ADDR_BITS
`define PC_ADDR_BITS 32
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

module vmem_lane_responder #(
   parameter int DEPTH = 1024,
   parameter int PORTS = 4
) (
   input  logic                  clk,
   input  logic                  nrst,
   vmem_lane_responder_if.slave  bus
);
   localparam int BEATS = 4 / PORTS;
   localparam int AW    = $clog2(DEPTH);
   localparam int AB    = `PC_ADDR_BITS;
   localparam int DW    = `DATAMEM_WIDTH;
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t          state_q, state_d;
   logic [BW-1:0]   beat_q;
   logic            is_store_q;
   logic [3:0]      lane_en_q;
   logic [AB-1:0]   addr_q  [4];
   logic [DW-1:0]   wdata_q [4];
   logic [DW-1:0]   rdata_q [4];
   logic [AW-1:0]   idx_w   [4];
   logic [3:0]      oob_w;
   logic [1:0]      lane_sel [PORTS];
   logic [DW-1:0]   mem [DEPTH];
   logic            accept;
   logic            last_beat;
   logic            unused_addr_bits;

   assign accept    = bus.req_valid && bus.req_ready;
   assign last_beat = (beat_q == BW'(BEATS - 1));
   assign unused_addr_bits = ^{addr_q[0], addr_q[1], addr_q[2], addr_q[3]};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         idx_w[i] = addr_q[i][AW+1:2];
`ifdef VMEM_OOB_ERR_EN
         oob_w[i] = (addr_q[i] >> (AW + 2)) != '0;
`else
         oob_w[i] = 1'b0;
`endif
      end
   end

   // Lanes handled this beat: b*PORTS .. b*PORTS+PORTS-1
   always_comb begin
      for (int p = 0; p < PORTS; p++) begin
         lane_sel[p] = 2'(int'(beat_q) * PORTS + p);
      end
   end

   always_ff @(posedge clk) begin
      if (!nrst) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = ACCESS;
         ACCESS:  if (last_beat) state_d = RESP;
         RESP:    if (bus.rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign bus.req_ready    = nrst && (state_q == IDLE);
   assign bus.rsp_valid    = (state_q == RESP);
   assign bus.rsp_is_store = is_store_q;
   assign bus.rsp_rdata0   = rdata_q[0];
   assign bus.rsp_rdata1   = rdata_q[1];
   assign bus.rsp_rdata2   = rdata_q[2];
   assign bus.rsp_rdata3   = rdata_q[3];

   always_ff @(posedge clk) begin
      if (!nrst) begin
         beat_q     <= '0;
         is_store_q <= 1'b0;
         lane_en_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            addr_q[i]  <= '0;
            wdata_q[i] <= '0;
            rdata_q[i] <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  beat_q     <= '0;
                  is_store_q <= bus.req_is_store;
                  lane_en_q  <= bus.req_lane_en;
                  addr_q[0]  <= bus.req_addr0;
                  addr_q[1]  <= bus.req_addr1;
                  addr_q[2]  <= bus.req_addr2;
                  addr_q[3]  <= bus.req_addr3;
                  wdata_q[0] <= bus.req_wdata0;
                  wdata_q[1] <= bus.req_wdata1;
                  wdata_q[2] <= bus.req_wdata2;
                  wdata_q[3] <= bus.req_wdata3;
                  for (int i = 0; i < 4; i++) rdata_q[i] <= '0;
               end
            end
            ACCESS: begin
               beat_q <= last_beat ? '0 : beat_q + 1'b1;
               if (!is_store_q) begin
                  for (int p = 0; p < PORTS; p++) begin
                     if (lane_en_q[lane_sel[p]] && !oob_w[lane_sel[p]])
                        rdata_q[lane_sel[p]] <= mem[idx_w[lane_sel[p]]];
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Later loop iterations win, so the highest enabled lane owns a shared word
   always_ff @(posedge clk) begin
      if (nrst && state_q == ACCESS && is_store_q) begin
         for (int p = 0; p < PORTS; p++) begin
            if (lane_en_q[lane_sel[p]] && !oob_w[lane_sel[p]])
               mem[idx_w[lane_sel[p]]] <= wdata_q[lane_sel[p]];
         end
      end
   end

`ifdef VMEM_OOB_ERR_EN
   logic err_q;

   always_ff @(posedge clk) begin
      if (!nrst) begin
         err_q <= 1'b0;
      end else if (state_q == IDLE && accept) begin
         err_q <= 1'b0;
      end else if (state_q == ACCESS) begin
         for (int p = 0; p < PORTS; p++) begin
            if (lane_en_q[lane_sel[p]] && oob_w[lane_sel[p]]) err_q <= 1'b1;
         end
      end
   end

   assign bus.rsp_err = err_q;
`endif
endmodule

// File: tb/tb_vmem_lane_responder.sv
// tb/tb_vmem_lane_responder.sv - directed bench running PORTS=4 and PORTS=1 responders in lockstep
`ifndef PC_ADDR_BITS
`define PC_ADDR_BITS 32
`endif
`ifndef DATAMEM_WIDTH
`define DATAMEM_WIDTH 32
`endif

module tb_vmem_lane_responder;
   logic clk = 1'b0;
   logic nrst = 1'b0;
   always #5 clk = ~clk;

   vmem_lane_responder_if b4 ();
   vmem_lane_responder_if b1 ();

   vmem_lane_responder #(.DEPTH(1024), .PORTS(4)) dut4 (.clk(clk), .nrst(nrst), .bus(b4));
   vmem_lane_responder #(.DEPTH(1024), .PORTS(1)) dut1 (.clk(clk), .nrst(nrst), .bus(b1));

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] r4 [4];
   logic [31:0] r1 [4];
   logic s4, s1, e4, e1;
   int lat4, lat1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic st, input logic [3:0] en,
                          input logic [31:0] a0, input logic [31:0] a1,
                          input logic [31:0] a2, input logic [31:0] a3,
                          input logic [31:0] w0, input logic [31:0] w1,
                          input logic [31:0] w2, input logic [31:0] w3);
      b4.req_is_store = st;  b1.req_is_store = st;
      b4.req_lane_en  = en;  b1.req_lane_en  = en;
      b4.req_addr0 = a0; b4.req_addr1 = a1; b4.req_addr2 = a2; b4.req_addr3 = a3;
      b1.req_addr0 = a0; b1.req_addr1 = a1; b1.req_addr2 = a2; b1.req_addr3 = a3;
      b4.req_wdata0 = w0; b4.req_wdata1 = w1; b4.req_wdata2 = w2; b4.req_wdata3 = w3;
      b1.req_wdata0 = w0; b1.req_wdata1 = w1; b1.req_wdata2 = w2; b1.req_wdata3 = w3;
   endtask

   task automatic accept_req(input string tag);
      chk({tag, ":rdy4"}, 32'(b4.req_ready), 32'd1);
      chk({tag, ":rdy1"}, 32'(b1.req_ready), 32'd1);
      b4.req_valid = 1'b1; b1.req_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      b4.req_valid = 1'b0; b1.req_valid = 1'b0;
   endtask

   task automatic run_req(input string tag);
      int k;
      bit got4, got1;
      accept_req(tag);
      chk({tag, ":busy4"}, 32'(b4.req_ready), 32'd0);
      got4 = 0; got1 = 0; k = 0; lat4 = -1; lat1 = -1;
      while (!(got4 && got1) && k < 20) begin
         @(posedge clk); @(negedge clk); k++;
         if (!got1) chk({tag, ":busy1"}, 32'(b1.req_ready), 32'd0);
         if (!got4 && b4.rsp_valid) begin
            got4 = 1; lat4 = k;
            r4[0] = b4.rsp_rdata0; r4[1] = b4.rsp_rdata1; r4[2] = b4.rsp_rdata2; r4[3] = b4.rsp_rdata3;
            s4 = b4.rsp_is_store;
`ifdef VMEM_OOB_ERR_EN
            e4 = b4.rsp_err;
`else
            e4 = 1'b0;
`endif
         end
         if (!got1 && b1.rsp_valid) begin
            got1 = 1; lat1 = k;
            r1[0] = b1.rsp_rdata0; r1[1] = b1.rsp_rdata1; r1[2] = b1.rsp_rdata2; r1[3] = b1.rsp_rdata3;
            s1 = b1.rsp_is_store;
`ifdef VMEM_OOB_ERR_EN
            e1 = b1.rsp_err;
`else
            e1 = 1'b0;
`endif
         end
      end
      chk({tag, ":lat4"}, 32'(lat4), 32'd1);
      chk({tag, ":lat1"}, 32'(lat1), 32'd4);
      @(posedge clk); @(negedge clk);
   endtask

   task automatic chk_data(input string tag, input logic st,
                           input logic [31:0] x0, input logic [31:0] x1,
                           input logic [31:0] x2, input logic [31:0] x3);
      logic [31:0] x [4];
      x[0] = x0; x[1] = x1; x[2] = x2; x[3] = x3;
      chk({tag, ":st4"}, 32'(s4), 32'(st));
      chk({tag, ":st1"}, 32'(s1), 32'(st));
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("%s:p4_lane%0d", tag, i), r4[i], x[i]);
         chk($sformatf("%s:p1_lane%0d", tag, i), r1[i], x[i]);
      end
   endtask

   initial begin
      int k;
      b4.req_valid = 1'b0; b1.req_valid = 1'b0;
      b4.rsp_ready = 1'b1; b1.rsp_ready = 1'b1;
      set_req(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

      // Reset values
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst:rdy4", 32'(b4.req_ready), 32'd0);
      chk("rst:rdy1", 32'(b1.req_ready), 32'd0);
      chk("rst:vld4", 32'(b4.rsp_valid), 32'd0);
      chk("rst:st4", 32'(b4.rsp_is_store), 32'd0);
      chk("rst:rd4", b4.rsp_rdata0, 32'd0);
`ifdef VMEM_OOB_ERR_EN
      chk("rst:err4", 32'(b4.rsp_err), 32'd0);
`endif
      nrst = 1'b1;
      #1;

      // Full store then load of the same four words
      set_req(1'b1, 4'hF, 32'h000, 32'h004, 32'h008, 32'h00C,
              32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
      run_req("st4w");
      chk_data("st4w", 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);

      set_req(1'b0, 4'hF, 32'h000, 32'h004, 32'h008, 32'h00C, 32'h0, 32'h0, 32'h0, 32'h0);
      run_req("ld4w");
      chk_data("ld4w", 1'b0, 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
`ifdef VMEM_OOB_ERR_EN
      chk("ld4w:err4", 32'(e4), 32'd0);
      chk("ld4w:err1", 32'(e1), 32'd0);
`endif

      // Sparse lane enable, lanes swapped to show per-lane addressing
      set_req(1'b0, 4'b0101, 32'h00C, 32'h004, 32'h000, 32'h008, 32'h0, 32'h0, 32'h0, 32'h0);
      run_req("ld0101");
      chk_data("ld0101", 1'b0, 32'h44444444, 32'h0, 32'h11111111, 32'h0);

      // Same-word collision: highest lane wins
      set_req(1'b1, 4'hF, 32'h010, 32'h010, 32'h010, 32'h010, 32'hA, 32'hB, 32'hC, 32'hD);
      run_req("stcol");
      set_req(1'b0, 4'hF, 32'h010, 32'h010, 32'h010, 32'h010, 32'h0, 32'h0, 32'h0, 32'h0);
      run_req("ldcol");
      chk_data("ldcol", 1'b0, 32'hD, 32'hD, 32'hD, 32'hD);

      // No lanes enabled still responds
      set_req(1'b0, 4'h0, 32'h000, 32'h004, 32'h008, 32'h00C, 32'h0, 32'h0, 32'h0, 32'h0);
      run_req("ldnone");
      chk_data("ldnone", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);

      // Response backpressure
      b4.rsp_ready = 1'b0; b1.rsp_ready = 1'b0;
      set_req(1'b0, 4'hF, 32'h000, 32'h004, 32'h008, 32'h00C, 32'h0, 32'h0, 32'h0, 32'h0);
      accept_req("hold");
      k = 0;
      while (!b1.rsp_valid && k < 20) begin
         @(posedge clk); @(negedge clk); k++;
      end
      chk("hold:arrive1", 32'(b1.rsp_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); @(negedge clk);
         chk($sformatf("hold%0d:vld4", c), 32'(b4.rsp_valid), 32'd1);
         chk($sformatf("hold%0d:vld1", c), 32'(b1.rsp_valid), 32'd1);
         chk($sformatf("hold%0d:rd4", c), b4.rsp_rdata0, 32'h11111111);
         chk($sformatf("hold%0d:rd1", c), b1.rsp_rdata3, 32'h44444444);
         chk($sformatf("hold%0d:rdy4", c), 32'(b4.req_ready), 32'd0);
      end
      b4.rsp_ready = 1'b1; b1.rsp_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("release:vld4", 32'(b4.rsp_valid), 32'd0);
      chk("release:vld1", 32'(b1.rsp_valid), 32'd0);
      chk("release:rdy4", 32'(b4.req_ready), 32'd1);
      chk("release:rdy1", 32'(b1.req_ready), 32'd1);

      // Byte address DEPTH*4 on lane 0
      set_req(1'b1, 4'b0001, 32'h1000, 32'h0, 32'h0, 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
      run_req("stoob");
`ifdef VMEM_OOB_ERR_EN
      chk("stoob:err4", 32'(e4), 32'd1);
      chk("stoob:err1", 32'(e1), 32'd1);
`endif
      set_req(1'b0, 4'b0001, 32'h000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      run_req("ldw0");
`ifdef VMEM_OOB_ERR_EN
      chk_data("ldw0", 1'b0, 32'h11111111, 32'h0, 32'h0, 32'h0);
`else
      chk_data("ldw0", 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
`endif
      set_req(1'b0, 4'b0001, 32'h1000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
      run_req("ldoob");
`ifdef VMEM_OOB_ERR_EN
      chk_data("ldoob", 1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
      chk("ldoob:err4", 32'(e4), 32'd1);
`else
      chk_data("ldoob", 1'b0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0);
`endif

      // Reset during ACCESS: PORTS=1 has committed lanes 0,1 only
      set_req(1'b1, 4'hF, 32'h020, 32'h024, 32'h028, 32'h02C, 32'h0, 32'h0, 32'h0, 32'h0);
      run_req("stzero");
      set_req(1'b1, 4'hF, 32'h020, 32'h024, 32'h028, 32'h02C, 32'h1, 32'h2, 32'h3, 32'h4);
      accept_req("strst");
      @(posedge clk); @(posedge clk); @(negedge clk);
      nrst = 1'b0;
      @(posedge clk); @(negedge clk);
      chk("midrst:vld4", 32'(b4.rsp_valid), 32'd0);
      chk("midrst:vld1", 32'(b1.rsp_valid), 32'd0);
      chk("midrst:rdy1", 32'(b1.req_ready), 32'd0);
      nrst = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("postrst:rdy4", 32'(b4.req_ready), 32'd1);
      chk("postrst:rdy1", 32'(b1.req_ready), 32'd1);
      chk("postrst:vld1", 32'(b1.rsp_valid), 32'd0);
      set_req(1'b0, 4'hF, 32'h020, 32'h024, 32'h028, 32'h02C, 32'h0, 32'h0, 32'h0, 32'h0);
      run_req("ldrst");
      chk("ldrst:p4_lane2", r4[2], 32'h3);
      chk("ldrst:p4_lane3", r4[3], 32'h4);
      chk("ldrst:p1_lane0", r1[0], 32'h1);
      chk("ldrst:p1_lane1", r1[1], 32'h2);
      chk("ldrst:p1_lane2", r1[2], 32'h0);
      chk("ldrst:p1_lane3", r1[3], 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/vmem_lane_responder.md
Name: vmem_lane_responder

Overview:
Memory-side responder for the vector coprocessor's 4-lane data-memory interface. Accepts one vector load or store request carrying four per-lane addresses and store words. Serializes the lanes onto PORTS physical RAM ports, then returns four load words or a store completion through a valid/ready response. Sits between the coprocessor's lane address/store/load buses and the data RAM; its response drives the coprocessor's load-done path.

Parameters:
DEPTH, 1024, data RAM size in DATAMEM_WIDTH-bit words; power of two.
PORTS, 4, physical RAM ports per cycle; legal values 1, 2, 4.
BEATS, 4/PORTS, derived (localparam), access cycles per request.

Ports:
clk  in  1  clock
nrst  in  1  reset; synchronous, active-low
req_valid  in  1  request present
req_ready  out  1  request can be accepted
req_is_store  in  1  1 = store request, 0 = load request
req_lane_en  in  4  per-lane enable; bit i qualifies lane i
req_addr0..req_addr3  in  `PC_ADDR_BITS each  per-lane byte address
req_wdata0..req_wdata3  in  `DATAMEM_WIDTH each  per-lane store data
rsp_valid  out  1  response present
rsp_ready  in  1  response consumed
rsp_is_store  out  1  echo of the accepted req_is_store
rsp_rdata0..rsp_rdata3  out  `DATAMEM_WIDTH each  per-lane load data
rsp_err  out  1  out-of-range access in the request; present only with VMEM_OOB_ERR_EN

Behaviour:
- Clock and reset: one clock, clk. Reset nrst is synchronous and active-low.
- Reset values: state IDLE; req_ready 0 while nrst low; rsp_valid 0; rsp_is_store 0; rsp_rdata* 0; rsp_err 0; beat counter 0. RAM contents are not reset.
- Word index for lane i = req_addr_i[log2(DEPTH)+1 : 2]. Address bits [1:0] are ignored. Upper address bits are handled per the Optional Feature.
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready = 1. On req_valid && req_ready:
  - latch all request fields (addresses, wdata, lane_en, is_store);
  - clear the rdata registers;
  - go to ACCESS with beat = 0.
- ACCESS: req_ready = 0. Beat b services lanes b*PORTS .. b*PORTS+PORTS-1.
  - Disabled lanes perform no RAM access. Their rdata stays 0.
  - Load: the RAM read is registered; lane rdata is captured at the end of the beat.
  - Store: the write commits at the end of the beat.
  - After beat BEATS-1, go to RESP.
- RESP: rsp_valid = 1. rsp_rdata*, rsp_is_store and rsp_err are held stable until rsp_valid && rsp_ready, then return to IDLE.
  - For a store response, rsp_rdata* = 0.
- Latency: with the request accepted at edge T, rsp_valid rises after edge T+BEATS (PORTS=4: one cycle after acceptance). Minimum request-to-request spacing is BEATS+2 cycles.
- No new request is accepted while in ACCESS or RESP. req_ready is combinational from state only, so there is no valid-to-ready path.
- Same-word collisions in one store request: the highest-numbered enabled lane wins.
- A load request reads RAM as left by all previously completed stores; no forwarding is needed.
- req_lane_en = 0 still runs the full sequence and responds with zero data (load) or completion (store).
- rsp_ready held high in RESP: completes in one cycle.
- rsp_ready asserted outside RESP: ignored.
- Reset mid-ACCESS: writes already committed remain, the current beat's write is suppressed, and the FSM goes to IDLE.

Optional Feature:
Macro VMEM_OOB_ERR_EN.
- Defined:
  - the rsp_err port exists;
  - an enabled lane whose byte address >= DEPTH*4 is out-of-range;
  - an out-of-range store is suppressed and an out-of-range load returns 0;
  - rsp_err is the OR over all enabled lanes of the request, valid with rsp_valid.
- Undefined:
  - no rsp_err port;
  - upper address bits are ignored, so the index wraps modulo DEPTH.

Test Plan:
- PORTS=4, store lanes 0-3 at addr 0x000/0x004/0x008/0x00C with data 0x11111111/0x22222222/0x33333333/0x44444444, then a load of the same addresses -> store rsp_valid 1 cycle after acceptance with rdata all 0; load returns the four words in lane order.
- PORTS=1, the same load -> rsp_valid 4 cycles after acceptance; req_ready 0 from acceptance until the response handshake.
- Load with lane_en=4'b0101 -> rsp_rdata1 = rsp_rdata3 = 0; lanes 0 and 2 carry RAM data.
- Store with all lanes at 0x010, data 0xA/0xB/0xC/0xD -> a later load at 0x010 returns 0xD.
- Hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and rsp_rdata* stable, req_ready 0; on release, return to IDLE the next cycle.
- DEPTH=1024, store to byte address 0x1000 -> with VMEM_OOB_ERR_EN, rsp_err=1 and word 0 unchanged; without it, the write lands at word 0. Separately, nrst low during ACCESS -> rsp_valid 0 and req_ready 1 after release.
